memory_stage: RTL

//   Y86-64 memory stage; consumes valE from execute, valA/valP from decode/fetch.

---
 rtl/memory_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage.
//   Performs at most one 8-byte little-endian access per instruction against a
//   byte-addressed data memory, one byte per clock, behind a start/busy/done
//   handshake. Produces valM, dmem_error and stat for writeback / PC update.
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_rst_n       synchronous active-low reset (memory contents are kept)
//   i_start       request, only sampled while idle
//   i_icode       instruction code, latched at start
//   i_val_e       ALU result / effective address, latched at start
//   i_val_a       operand A / pop-ret stack address, latched at start
//   i_val_p       next PC (call return address), latched at start
//   o_busy        high whenever the stage is not idle
//   o_done        one-cycle completion pulse
//   o_val_m       read data (0 for non-read operations)
//   o_dmem_error  access address out of range
//   o_stat        1=AOK 2=HLT 3=ADR 4=INS
module memory_stage #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [3:0]  i_icode,
   input  logic [63:0] i_val_e,
   input  logic [63:0] i_val_a,
   input  logic [63:0] i_val_p,
   output logic        o_busy,
   output logic        o_done,
   output logic [63:0] o_val_m,
   output logic        o_dmem_error,
   output logic [2:0]  o_stat
);

   localparam int unsigned AW       = $clog2(MEM_BYTES);
   localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e        r_state;
   state_e        w_state_next;
   logic [2:0]    r_cnt;
   logic          r_wr;
   logic [AW-1:0] r_addr;
   logic [63:0]   r_wdata;
   logic [63:0]   r_val_m;
   logic          r_err;
   logic [2:0]    r_stat;
   logic [7:0]    r_mem [MEM_BYTES];

   logic          w_mem_op;
   logic          w_write;
   logic [63:0]   w_addr;
   logic [63:0]   w_wdata;
   logic          w_bad;
   logic [2:0]    w_stat;
   logic          w_accept;
   logic [AW-1:0] w_idx;

   // Decode the access described by the incoming instruction.
   always_comb begin
      w_mem_op = 1'b1;
      w_write  = 1'b0;
      w_addr   = i_val_e;
      w_wdata  = i_val_a;
      case (i_icode)
         4'h4: w_write = 1'b1;                              // rmmovq
         4'h5: w_write = 1'b0;                              // mrmovq
         4'hA: w_write = 1'b1;                              // pushq
         4'hB: w_addr  = i_val_a;                           // popq
         4'h8: begin w_write = 1'b1; w_wdata = i_val_p; end // call
         4'h9: w_addr  = i_val_a;                           // ret
         default: w_mem_op = 1'b0;
      endcase
   end

   // A single unsigned compare also catches wrapped / negative addresses.
   assign w_bad = w_mem_op && (w_addr > MAX_ADDR);

   always_comb begin
      if (w_bad)                w_stat = 3'd3;
      else if (i_icode > 4'hB)  w_stat = 3'd4;
      else if (i_icode == 4'h0) w_stat = 3'd2;
      else                      w_stat = 3'd1;
   end

   assign w_accept = (r_state == StIdle) && i_start;
   // Legal addresses end at MEM_BYTES-1, so addr + cnt never overflows AW bits.
   assign w_idx    = r_addr + AW'(r_cnt);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (i_start) w_state_next = (w_mem_op && !w_bad) ? StAccess : StDone;
         end
         StAccess: begin
            if (r_cnt == 3'd7) w_state_next = StDone;
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt   <= 3'd0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 64'd0;
         r_val_m <= 64'd0;
         r_err   <= 1'b0;
         r_stat  <= 3'd1;
      end else if (w_accept) begin
         r_cnt   <= 3'd0;
         r_wr    <= w_write;
         r_addr  <= w_addr[AW-1:0];
         r_wdata <= w_wdata;
         r_val_m <= 64'd0;
         r_err   <= w_bad;
         r_stat  <= w_stat;
      end else if (r_state == StAccess) begin
         r_cnt <= r_cnt + 3'd1;
         if (!r_wr) r_val_m[{r_cnt, 3'b000} +: 8] <= r_mem[w_idx];
      end
   end

   // No reset on the array; a reset edge suppresses the pending byte write.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && (r_state == StAccess) && r_wr) begin
         r_mem[w_idx] <= r_wdata[{r_cnt, 3'b000} +: 8];
      end
   end

   assign o_busy       = (r_state != StIdle);
   assign o_done       = (r_state == StDone);
   assign o_val_m      = r_val_m;
   assign o_dmem_error = r_err;
   assign o_stat       = r_stat;

endmodule
